// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake plus decoded fields
interface decode_stage_if;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  alu_src, size;
  logic [3:0]  alu_ctrl;
  logic [2:0]  m_op;
  logic        m_en, mreq, write, reg_write, illegal;
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_src, alu_ctrl,
           m_en, m_op, mreq, write, reg_write, illegal, size
  );
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_src, alu_ctrl,
           m_en, m_op, mreq, write, reg_write, illegal, size
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: instruction FIFO with bypass feeding a registered RV32I(M) decoder
module decode_stage #(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_n;
  logic          rdy, push, free, pop, byp, wr, load;
  logic [31:0]   inst, pc, d_imm;
  logic [6:0]    op, f7;
  logic [2:0]    f3;
  logic [3:0]    base, d_alu;
  logic          lui, auipc, jal, jalr, br, ld, st, opi, opr, r_alt, r_mul, mop, ill, alt;
  assign io.in_ready = rdy;
  assign push = io.in_valid & rdy;
  assign free = !io.out_valid | io.out_ready;
  assign pop  = free & (cnt != '0);
  assign byp  = free & (cnt == '0) & push;
  assign wr   = push & !byp;
  assign load = pop | byp;
  assign cnt_n = cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
  assign {inst, pc} = byp ? {io.in_inst, io.in_pc} : mem[rp];
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign lui   = op == 7'h37;
  assign auipc = op == 7'h17;
  assign jal   = op == 7'h6f;
  assign jalr  = op == 7'h67;
  assign br    = op == 7'h63;
  assign ld    = op == 7'h03;
  assign st    = op == 7'h23;
  assign opi   = op == 7'h13;
  assign opr   = op == 7'h33;
  assign r_alt = f7 == 7'h20;
  assign r_mul = f7 == 7'h01;
  assign mop   = opr & r_mul;
  assign alt   = opr ? r_alt : inst[30];
  assign ill = !(lui | auipc | jal | jalr | br | ld | st | opi | opr)
             | (ld & (f3 == 3'd3 | f3[2:1] == 2'b11))
             | (st & (f3[2] | f3 == 3'd3))
             | (opr & !(f7 == 7'h00 | r_alt | r_mul))
             | (mop & !ENABLE_M);
  assign d_imm = (lui | auipc)       ? {inst[31:12], 12'h000}
               : jal                 ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}
               : br                  ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}
               : st                  ? {{21{inst[31]}}, inst[30:25], inst[11:7]}
               : (jalr | ld | opi)   ? {{21{inst[31]}}, inst[30:20]}
               : 32'h0;
  always_comb begin
    case (f3)
      3'd0: base = (opr & r_alt) ? 4'd1 : 4'd0;
      3'd1: base = 4'd5;
      3'd2: base = 4'd8;
      3'd3: base = 4'd9;
      3'd4: base = 4'd4;
      3'd5: base = alt ? 4'd7 : 4'd6;
      3'd6: base = 4'd3;
      3'd7: base = 4'd2;
    endcase
  end
  assign d_alu = (opi | (opr & !mop)) ? base : 4'd0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {io.in_inst, io.in_pc};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      rdy          <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_pc    <= '0;
      io.rd        <= '0;
      io.rs1       <= '0;
      io.rs2       <= '0;
      io.imm       <= '0;
      io.alu_src   <= '0;
      io.alu_ctrl  <= '0;
      io.m_en      <= 1'b0;
      io.m_op      <= '0;
      io.mreq      <= 1'b0;
      io.write     <= 1'b0;
      io.reg_write <= 1'b0;
      io.illegal   <= 1'b0;
      io.size      <= '0;
    end else if (io.flush) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      rdy          <= 1'b1;
      io.out_valid <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt          <= cnt_n;
      rdy          <= cnt_n != (AW+1)'(DEPTH);
      io.out_valid <= load | (io.out_valid & !io.out_ready);
      if (load) begin
        io.out_pc    <= pc;
        io.rd        <= inst[11:7];
        io.rs1       <= inst[19:15];
        io.rs2       <= inst[24:20];
        io.imm       <= d_imm;
        io.alu_src   <= {auipc | jal, lui | auipc | jal | jalr | ld | st | opi};
        io.alu_ctrl  <= d_alu;
        io.m_en      <= mop & ENABLE_M;
        io.m_op      <= mop ? f3 : 3'd0;
        io.mreq      <= ld | st;
        io.write     <= st;
        io.reg_write <= (lui | auipc | jal | jalr | ld | opi | opr) & (inst[11:7] != 5'd0) & !ill;
        io.illegal   <= ill;
        io.size      <= f3[1:0];
      end
    end
  end
endmodule
